// File: rtl/sweep_pkg.sv
// rtl/sweep_pkg.sv - shared types and defaults for the sweep controller
package sweep_pkg;

   // Default data/count/limit width
   localparam int WIDTH_DEF = 8;

   // Controller states: IDLE parks the counter, UP/DOWN let it step
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      DOWN = 2'd2
   } state_t;

endpackage

// File: rtl/sweep_limit_cmp.sv
// rtl/sweep_limit_cmp.sv - turn-around detectors one step before each bound
module sweep_limit_cmp
   import sweep_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] count,
   input  logic [WIDTH-1:0] lo_l,
   input  logic [WIDTH-1:0] hi_l,
   output logic             at_top,
   output logic             at_bottom
);

   // Flag one step early so the state change coincides with the counter
   // landing on the bound; lo_l < hi_l keeps both adjustments from wrapping.
   assign at_top    = (count == (hi_l - WIDTH'(1)));
   assign at_bottom = (count == (lo_l + WIDTH'(1)));

endmodule

// File: rtl/ud_counter.sv
// rtl/ud_counter.sv - loadable up/down counter driven by the sweep controller
module ud_counter
   import sweep_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             u_d,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] count
);

   // Load has priority; otherwise step every edge (there is no hold)
   always_ff @(posedge clk) begin
      if (!rst)
         count <= '0;
      else if (load)
         count <= data;
      else if (u_d)
         count <= count + WIDTH'(1);
      else
         count <= count - WIDTH'(1);
   end

endmodule

// File: rtl/sweep_ctrl.sv
// rtl/sweep_ctrl.sv - triangle sweep controller for an external up/down counter
module sweep_ctrl
   import sweep_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic [WIDTH-1:0] lo_lim,
   input  logic [WIDTH-1:0] hi_lim,
   input  logic [3:0]       n_sweeps,
   input  logic [WIDTH-1:0] count,
   output logic             load,
   output logic             u_d,
   output logic [WIDTH-1:0] data,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [3:0]       sweep_cnt
);

   state_t           state, state_n;
   logic [WIDTH-1:0] lo_l, hi_l;
   logic [3:0]       n_l;
   logic             at_top, at_bottom;
   logic             accept, reject, sweep_end, run_end;

   sweep_limit_cmp #(.WIDTH(WIDTH)) u_cmp (
      .count     (count),
      .lo_l      (lo_l),
      .hi_l      (hi_l),
      .at_top    (at_top),
      .at_bottom (at_bottom)
   );

   // Counter controls decode straight from the state register, so a state
   // change reaches load/u_d with no extra cycle and without glitches.
   assign load = (state == IDLE);
   assign u_d  = (state == UP);
   assign data = lo_l;
   assign busy = (state != IDLE);

   // Next-state and event decode; stop outranks everything but reset
   always_comb begin
      state_n   = state;
      accept    = 1'b0;
      reject    = 1'b0;
      sweep_end = 1'b0;
      run_end   = 1'b0;
      case (state)
         IDLE: begin
            if (!stop && start) begin
               if (lo_lim < hi_lim) begin
                  accept  = 1'b1;
                  state_n = UP;
               end else begin
                  reject = 1'b1;
               end
            end
         end
         UP: begin
            if (stop)
               state_n = IDLE;
            else if (at_top)
               state_n = DOWN;
         end
         DOWN: begin
            if (stop) begin
               state_n = IDLE;
            end else if (at_bottom) begin
               sweep_end = 1'b1;
               if ((n_l != 4'd0) && ((sweep_cnt + 4'd1) == n_l)) begin
                  run_end = 1'b1;
                  state_n = IDLE;
               end else begin
                  state_n = UP;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State, latched run parameters, sweep counter and one-cycle pulses
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         lo_l      <= '0;
         hi_l      <= '0;
         n_l       <= 4'd0;
         sweep_cnt <= 4'd0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state <= state_n;
         done  <= run_end;
         err   <= reject;
         if (accept) begin
            lo_l      <= lo_lim;
            hi_l      <= hi_lim;
            n_l       <= n_sweeps;
            sweep_cnt <= 4'd0;
         end else if (sweep_end) begin
            sweep_cnt <= sweep_cnt + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_sweep_ctrl.sv
// tb/tb_sweep_ctrl.sv - closed-loop scoreboard bench for sweep_ctrl
module tb_sweep_ctrl;

   logic       clk;
   logic       rst;
   logic       start;
   logic       stop;
   logic [7:0] lo_lim, hi_lim;
   logic [3:0] n_sweeps;
   logic [7:0] count;
   logic       load, u_d;
   logic [7:0] data;
   logic       busy, done, err;
   logic [3:0] sweep_cnt;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int cnt;
      bit dn;
      bit bs;
   } exp_t;

   exp_t sb[$];

   sweep_ctrl #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .stop      (stop),
      .lo_lim    (lo_lim),
      .hi_lim    (hi_lim),
      .n_sweeps  (n_sweeps),
      .count     (count),
      .load      (load),
      .u_d       (u_d),
      .data      (data),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .sweep_cnt (sweep_cnt)
   );

   ud_counter #(.WIDTH(8)) u_counter (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .u_d   (u_d),
      .data  (data),
      .count (count)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   // Expected per-cycle counter trace of a run: lo, then n triangles back to lo
   task automatic push_run(input int lo, input int hi, input int n);
      exp_t e;
      int   v;
      e.cnt = lo; e.dn = 1'b0; e.bs = 1'b1;
      sb.push_back(e);
      for (int s = 0; s < n; s++) begin
         for (v = lo + 1; v <= hi; v++) begin
            e.cnt = v; sb.push_back(e);
         end
         for (v = hi - 1; v >= lo; v--) begin
            e.cnt = v; sb.push_back(e);
         end
      end
      sb[sb.size()-1].dn = 1'b1;
      sb[sb.size()-1].bs = 1'b0;
   endtask

   task automatic do_run(input int lo, input int hi, input int n, input bit hold_start);
      exp_t e;
      push_run(lo, hi, n);
      lo_lim   = 8'(lo);
      hi_lim   = 8'(hi);
      n_sweeps = 4'(n);
      start    = 1'b1;
      while (sb.size() > 0) begin
         cyc();
         if (!hold_start) start = 1'b0;
         e = sb.pop_front();
         check_eq("count", 32'(count), e.cnt);
         check_eq("done", 32'(done), 32'(e.dn));
         check_eq("busy", 32'(busy), 32'(e.bs));
         check_eq("err", 32'(err), 0);
      end
   endtask

   // Latch a new lower bound by starting and immediately stopping, which
   // parks the counter on it so the next run begins from that value.
   task automatic prime(input int x);
      lo_lim   = 8'(x);
      hi_lim   = 8'(x + 1);
      n_sweeps = 4'd1;
      start    = 1'b1;
      cyc();
      start = 1'b0;
      stop  = 1'b1;
      cyc();
      stop = 1'b0;
      check_eq("prime_done", 32'(done), 0);
      cyc();
      check_eq("prime_count", 32'(count), 32'(x));
      check_eq("prime_busy", 32'(busy), 0);
   endtask

   initial begin
      int  guard;
      bit  seen_done;
      clk      = 1'b0;
      rst      = 1'b0;
      start    = 1'b0;
      stop     = 1'b0;
      lo_lim   = 8'd0;
      hi_lim   = 8'd0;
      n_sweeps = 4'd0;

      // reset state
      cyc(); cyc();
      check_eq("rst_load", 32'(load), 1);
      check_eq("rst_u_d", 32'(u_d), 0);
      check_eq("rst_data", 32'(data), 0);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_done", 32'(done), 0);
      check_eq("rst_err", 32'(err), 0);
      check_eq("rst_sweep_cnt", 32'(sweep_cnt), 0);
      rst = 1'b1;
      cyc();

      // single triangle 10..13..10
      prime(10);
      do_run(10, 13, 1, 1'b0);
      check_eq("run1_sweep_cnt", 32'(sweep_cnt), 1);
      cyc();
      check_eq("run1_hold", 32'(count), 10);
      check_eq("run1_done_once", 32'(done), 0);

      // rejected start: lo == hi
      lo_lim = 8'd20; hi_lim = 8'd20; start = 1'b1;
      cyc();
      start = 1'b0;
      check_eq("rej_err", 32'(err), 1);
      check_eq("rej_busy", 32'(busy), 0);
      check_eq("rej_data", 32'(data), 10);
      cyc();
      check_eq("rej_err_pulse", 32'(err), 0);
      check_eq("rej_count", 32'(count), 10);
      check_eq("rej_busy2", 32'(busy), 0);

      // stop beats start in IDLE, for both a bad and a good request
      stop = 1'b1; start = 1'b1;
      cyc();
      check_eq("ss_err", 32'(err), 0);
      check_eq("ss_busy", 32'(busy), 0);
      lo_lim = 8'd1; hi_lim = 8'd50;
      cyc();
      check_eq("ss_busy2", 32'(busy), 0);
      check_eq("ss_err2", 32'(err), 0);
      stop = 1'b0; start = 1'b0;
      cyc();

      // adjacent bounds, three sweeps
      prime(5);
      do_run(5, 6, 3, 1'b0);
      check_eq("adj_sweep_cnt", 32'(sweep_cnt), 3);

      // endless run aborted by stop at 100 while rising
      lo_lim = 8'd0; hi_lim = 8'd255; n_sweeps = 4'd0; start = 1'b1;
      cyc();
      start = 1'b0;
      guard = 0;
      seen_done = 1'b0;
      while (count != 8'd100 && guard < 400) begin
         cyc();
         if (done) seen_done = 1'b1;
         guard++;
      end
      check_eq("stop_reach100", 32'(count), 100);
      check_eq("stop_rising", 32'(u_d), 1);
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      check_eq("stop_busy", 32'(busy), 0);
      check_eq("stop_load", 32'(load), 1);
      check_eq("stop_step", 32'(count), 101);
      if (done) seen_done = 1'b1;
      cyc();
      if (done) seen_done = 1'b1;
      check_eq("stop_reload", 32'(count), 0);
      check_eq("stop_no_done", 32'(seen_done), 0);
      check_eq("stop_sweep_cnt", 32'(sweep_cnt), 0);

      // reset while descending through 7
      prime(2);
      lo_lim = 8'd2; hi_lim = 8'd9; n_sweeps = 4'd1; start = 1'b1;
      cyc();
      start = 1'b0;
      guard = 0;
      while (!(busy && !u_d && count == 8'd7) && guard < 50) begin
         cyc();
         guard++;
      end
      check_eq("mid_found", 32'(count), 7);
      rst = 1'b0;
      cyc();
      check_eq("mid_load", 32'(load), 1);
      check_eq("mid_u_d", 32'(u_d), 0);
      check_eq("mid_data", 32'(data), 0);
      check_eq("mid_busy", 32'(busy), 0);
      check_eq("mid_done", 32'(done), 0);
      check_eq("mid_err", 32'(err), 0);
      check_eq("mid_sweep_cnt", 32'(sweep_cnt), 0);
      rst = 1'b1;
      do_run(0, 3, 1, 1'b0);
      check_eq("post_rst_sweep_cnt", 32'(sweep_cnt), 1);

      // start held high: the next run begins right after done
      do_run(0, 2, 2, 1'b1);
      check_eq("held_sweep_cnt", 32'(sweep_cnt), 2);
      cyc();
      check_eq("held_restart_busy", 32'(busy), 1);
      check_eq("held_restart_err", 32'(err), 0);
      check_eq("held_restart_cnt", 32'(sweep_cnt), 0);
      start = 1'b0;
      stop  = 1'b1;
      cyc();
      stop = 1'b0;
      cyc();
      check_eq("held_end_busy", 32'(busy), 0);
      check_eq("held_end_count", 32'(count), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
